ysyx_24100012_alu_arb: RTL

Shares the single `ysyx_24100012_alu` instance between two requesters: port 0 is the LSU address generator and port 1 is the EXU. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates per cycle, drives the granted operands into the ALU, captures the result in a one-entry result register, and returns it only to the requester that owns it. Throughput is one operation per cycle when responses drain.

---
 rtl/ysyx_24100012_pkg.sv | 19 +
 rtl/ysyx_24100012_alu.sv | 37 +++
 rtl/ysyx_24100012_alu_arb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_24100012_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ysyx_24100012_pkg
// Description : Shared constants for the ALU and its two-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100012_pkg;

  localparam int         ALU_DATA_WIDTH = 32;
  localparam int         ALU_N_SEL      = 4;

  localparam logic [3:0] ALU_SEL_ADD    = 4'b0000;

  // Requester identifiers, also used as the grant / owner encoding
  localparam logic       ALU_REQ_LSU    = 1'b0;
  localparam logic       ALU_REQ_EXU    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100012_alu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100012_alu
// Description : Combinational ALU. Only the add operation is implemented;
//               every other select returns zero. clk/rst/inst_type exist for
//               port compatibility and do not influence the result.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100012_alu
  import ysyx_24100012_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int N_SEL      = ALU_N_SEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            inst_type,
  input  logic [N_SEL-1:0]      alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_result
);

  // Compatibility-only inputs folded together so they are visibly consumed
  logic w_unused_ports;
  assign w_unused_ports = ^{clk, rst, inst_type};

  // Modulo-2^DATA_WIDTH add; the carry out is simply dropped
  always_comb begin
    alu_result = '0;
    if (alu_sel == N_SEL'(ALU_SEL_ADD)) begin
      alu_result = alu_a + alu_b;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24100012_alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100012_alu_arb
// Description : Shares one ALU between the LSU address generator (port 0) and
//               the EXU (port 1). Per-cycle grant, one-entry result register,
//               result returned only to its owner. Full throughput when the
//               owner drains every cycle.
//               Build option YSYX_24100012_ALU_ARB_RR_EN: round-robin
//               tie-break; otherwise port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100012_alu_arb
  import ysyx_24100012_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int N_SEL      = ALU_N_SEL
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [2:0]            req0_type,
  input  logic [N_SEL-1:0]      req0_sel,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [2:0]            req1_type,
  input  logic [N_SEL-1:0]      req1_sel,

  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp_data
);

  logic                  r_res_vld;
  logic                  r_res_own;
  logic [DATA_WIDTH-1:0] r_res_q;

  logic                  w_own_ready;
  logic                  w_space;
  logic                  w_drain;
  logic                  w_grant;
  logic                  w_accept;

  logic [DATA_WIDTH-1:0] w_alu_a;
  logic [DATA_WIDTH-1:0] w_alu_b;
  logic [2:0]            w_alu_type;
  logic [N_SEL-1:0]      w_alu_sel;
  logic [DATA_WIDTH-1:0] w_alu_res;

  // The register frees up either because it is empty or because its owner
  // takes the result this very cycle (refill with no bubble).
  assign w_own_ready = (r_res_own == ALU_REQ_EXU) ? resp1_ready : resp0_ready;
  assign w_space     = !r_res_vld || w_own_ready;
  assign w_drain     = r_res_vld && w_own_ready;

`ifdef YSYX_24100012_ALU_ARB_RR_EN
  logic r_last;

  // Tie goes to whoever was not granted last; a lone requester always wins
  always_comb begin
    w_grant = ALU_REQ_LSU;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else if (req1_valid) begin
      w_grant = ALU_REQ_EXU;
    end
  end

  // Last-granted pointer moves only on an accepted request; reset favours port 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= ALU_REQ_EXU;
    end else if (w_accept) begin
      r_last <= w_grant;
    end
  end
`else
  // Fixed priority: port 1 is granted only while port 0 is idle
  always_comb begin
    w_grant = ALU_REQ_LSU;
    if (!req0_valid && req1_valid) begin
      w_grant = ALU_REQ_EXU;
    end
  end
`endif

  // Readies are also gated by rst so nothing is taken while reset is held
  assign req0_ready = rst && w_space && (w_grant == ALU_REQ_LSU) && req0_valid;
  assign req1_ready = rst && w_space && (w_grant == ALU_REQ_EXU) && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  // Operand mux; with no grant the select rests on port 0
  assign w_alu_a    = (w_grant == ALU_REQ_EXU) ? req1_a    : req0_a;
  assign w_alu_b    = (w_grant == ALU_REQ_EXU) ? req1_b    : req0_b;
  assign w_alu_type = (w_grant == ALU_REQ_EXU) ? req1_type : req0_type;
  assign w_alu_sel  = (w_grant == ALU_REQ_EXU) ? req1_sel  : req0_sel;

  ysyx_24100012_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_SEL      (N_SEL)
  ) u_alu (
    .clk        (clk),
    .rst        (rst),
    .inst_type  (w_alu_type),
    .alu_sel    (w_alu_sel),
    .alu_a      (w_alu_a),
    .alu_b      (w_alu_b),
    .alu_result (w_alu_res)
  );

  // Result register: accept overwrites (even while draining), drain alone empties
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_res_vld <= 1'b0;
      r_res_own <= ALU_REQ_LSU;
      r_res_q   <= '0;
    end else if (w_accept) begin
      r_res_vld <= 1'b1;
      r_res_own <= w_grant;
      r_res_q   <= w_alu_res;
    end else if (w_drain) begin
      r_res_vld <= 1'b0;
    end
  end

  assign resp0_valid = r_res_vld && (r_res_own == ALU_REQ_LSU);
  assign resp1_valid = r_res_vld && (r_res_own == ALU_REQ_EXU);
  assign resp_data   = r_res_q;

endmodule
`default_nettype wire
